// File: rtl/accum_alu_n.sv
// accum_alu_n: two-stage pipelined accumulator with ADD/SUB/LOAD/CLEAR opcodes,
// carry/overflow flags, sticky overflow, an operation counter and two
// active-low hex 7-segment decoders for the low byte of the accumulator.
// Stage 1 registers the qualified operand/opcode; stage 2 executes the
// registered op against the accumulator.
// Optional build macro ACC_SATURATE_EN: ADD/SUB signed overflow clamps the
// accumulator to the most-positive / most-negative value instead of wrapping.
module accum_alu_n #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               IN_VALID,
  input  logic [1:0]         OP,
  input  logic [WIDTH-1:0]   IN,
  output logic [WIDTH-1:0]   RESULT,
  output logic               CARRY,
  output logic               OVERFLOW,
  output logic               OVF_STICKY,
  output logic               RESULT_VALID,
  output logic [COUNT_W-1:0] OP_COUNT,
  output logic [6:0]         OUT_LSB,
  output logic [6:0]         OUT_MSB
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Stage 1 (capture) registers
  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_b;

  // Stage 2 (execute) architectural state
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;
  logic               r_ovf;
  logic               r_sticky;
  logic               r_result_valid;
  logic [COUNT_W-1:0] r_op_count;

  // Execute-stage datapath
  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_ovf;
  logic [WIDTH-1:0] w_arith_res;

  // Capture the operand and opcode whenever the input is qualified.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!RESET) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_b     <= '0;
    end else begin
      r_s1_valid <= IN_VALID;
      if (IN_VALID) begin
        r_s1_op <= op_e'(OP);
        r_s1_b  <= IN;
      end
    end
  end

  // Shared adder: SUB is ACC + ~B + 1, so the carry-out doubles as "no borrow".
  always_comb begin
    // NOTE: every combinational output is assigned up front so no path can
    // leave a value unassigned and infer a latch.
    w_is_sub    = (r_s1_op == OP_SUB);
    w_b_eff     = w_is_sub ? ~r_s1_b : r_s1_b;
    w_sum       = {1'b0, r_acc} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
    w_ovf       = (r_acc[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
    w_arith_res = w_sum[WIDTH-1:0];
`ifdef ACC_SATURATE_EN
    if (w_ovf) begin
      // Overflow direction follows the accumulator sign: positive ACC can only
      // overflow upward, negative ACC only downward.
      w_arith_res = r_acc[WIDTH-1] ? MAX_NEG : MAX_POS;
    end
`endif
  end

  // Execute the captured op; ACC is read and written here, so back-to-back ops
  // see each other's results without forwarding.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_acc          <= '0;
      r_carry        <= 1'b0;
      r_ovf          <= 1'b0;
      r_sticky       <= 1'b0;
      r_result_valid <= 1'b0;
      r_op_count     <= '0;
    end else begin
      r_result_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_op_count <= r_op_count + COUNT_W'(1);
        case (r_s1_op)
          OP_ADD, OP_SUB: begin
            r_acc    <= w_arith_res;
            r_carry  <= w_sum[WIDTH];
            r_ovf    <= w_ovf;
            r_sticky <= r_sticky | w_ovf;
          end
          OP_LOAD: begin
            r_acc   <= r_s1_b;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
          end
          OP_CLEAR: begin
            r_acc    <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_sticky <= 1'b0;
          end
          default: begin
            r_acc <= r_acc;
          end
        endcase
      end
    end
  end

  // Active-low hex decoder, bit0 = segment a ... bit6 = segment g.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign RESULT       = r_acc;
  assign CARRY        = r_carry;
  assign OVERFLOW     = r_ovf;
  assign OVF_STICKY   = r_sticky;
  assign RESULT_VALID = r_result_valid;
  assign OP_COUNT     = r_op_count;
  assign OUT_LSB      = seg7(r_acc[3:0]);
  assign OUT_MSB      = seg7(r_acc[7:4]);

endmodule

// File: tb/tb_accum_alu_n.sv
// Testbench for accum_alu_n (WIDTH=8, COUNT_W=8). Directed vectors push their
// expected response into a scoreboard queue; a negedge monitor pops and
// compares whenever RESULT_VALID is high.
module tb_accum_alu_n;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;
`ifdef ACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] in_data;
  logic [7:0] result;
  logic       carry, overflow, ovf_sticky, result_valid;
  logic [7:0] op_count;
  logic [6:0] out_lsb, out_msb;

  accum_alu_n #(.WIDTH(8), .COUNT_W(8)) dut (
    .CLK(clk), .RESET(rst_n), .IN_VALID(in_valid), .OP(op), .IN(in_data),
    .RESULT(result), .CARRY(carry), .OVERFLOW(overflow), .OVF_STICKY(ovf_sticky),
    .RESULT_VALID(result_valid), .OP_COUNT(op_count),
    .OUT_LSB(out_lsb), .OUT_MSB(out_msb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       o;
    logic       s;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] exp_cnt = 8'd0;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         run_len = 0;
  int         last_run = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      run_len++;
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got RESULT_VALID=1 result 0x%0h expected no result (t=%0t)",
                 result, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("result",   result,     mon_e.res);
        check("carry",    carry,      mon_e.c);
        check("overflow", overflow,   mon_e.o);
        check("sticky",   ovf_sticky, mon_e.s);
        check("op_count", op_count,   mon_e.cnt);
        check("out_lsb",  out_lsb,    seg_tab[mon_e.res[3:0]]);
        check("out_msb",  out_msb,    seg_tab[mon_e.res[7:4]]);
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic send(input logic [1:0] o, input logic [7:0] b,
                      input logic [7:0] r, input logic c, input logic ov, input logic s);
    exp_t x;
    in_valid = 1'b1;
    op       = o;
    in_data  = b;
    exp_cnt  = exp_cnt + 8'd1;
    x.res = r; x.c = c; x.o = ov; x.s = s; x.cnt = exp_cnt;
    sb_q.push_back(x);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_result"},   result,       8'h00);
    check({tag, "_carry"},    carry,        1'b0);
    check({tag, "_overflow"}, overflow,     1'b0);
    check({tag, "_sticky"},   ovf_sticky,   1'b0);
    check({tag, "_valid"},    result_valid, 1'b0);
    check({tag, "_op_count"}, op_count,     8'h00);
    check({tag, "_out_lsb"},  out_lsb,      7'h40);
    check({tag, "_out_msb"},  out_msb,      7'h40);
  endtask

  initial begin
    // Reset held for two edges while a valid ADD is presented.
    rst_n = 1'b0; in_valid = 1'b1; op = ADD; in_data = 8'h55;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_idle("reset");
    idle(2);

    // Add overflow: LOAD 0x70, ADD 0x20.
    send(LOAD, 8'h70, 8'h70, 1'b0, 1'b0, 1'b0);
    send(ADD,  8'h20, SAT ? 8'h7F : 8'h90, 1'b0, 1'b1, 1'b1);
    idle(4);
    check("run_add_ovf", last_run, 2);

    // Sticky survives a clean op, CLEAR drops it.
    send(ADD, 8'h01, SAT ? 8'h7F : 8'h91, 1'b0, SAT, 1'b1);
    send(CLR, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b0);

    // Subtract with borrow, then without.
    send(LOAD, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
    send(SUB,  8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
    send(SUB,  8'h01, 8'hEF, 1'b1, 1'b0, 1'b0);

    // Negative overflow: 0x80 - 1.
    send(LOAD, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
    send(SUB,  8'h01, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b1);
    send(CLR,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("run_mixed", last_run, 8);

    // Counter wrap and full throughput: reset, then 256 back-to-back ADD 1.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 1; i <= 256; i++) begin
      logic [7:0] r;
      logic       c, ov, s;
      if (SAT) begin
        r  = (i < 128) ? i[7:0] : 8'h7F;
        c  = 1'b0;
        ov = (i >= 128);
      end else begin
        r  = i[7:0];
        c  = (i == 256);
        ov = (i == 128);
      end
      s = (i >= 128);
      send(ADD, 8'h01, r, c, ov, s);
    end
    idle(4);
    check("run_256", last_run, 256);
    check("wrap_op_count", op_count, 8'h00);

    // Reset arriving on the execute edge flushes the in-flight ADD.
    in_valid = 1'b1; op = ADD; in_data = 8'h05;
    @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("mid_reset");

    // Bounded drain of any outstanding expectations.
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drain", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
